sequencer_mc: RTL and testbench

//  Multi-cycle control sequencer for the basic accumulator CPU, successor to the 3-bit-opcode sequencer.
//  - Adds parametrised RAM wait states, shift/jump/branch-if-zero opcodes, a HALT/run mechanism,
//    and a req/ack output port that replaces the LED/SW path.
//  - Drives the same datapath strobes (bus enables, register loads, ALU selects, RAM NCE/NOE/NWE).

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/ram_wait_timer.sv | 37 +++
 rtl/sequencer_mc.sv | 184 ++++++++++++++++++
 tb/tb_sequencer_mc.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU control path.
// Opcode map, sequencer states and wait-counter sizing.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_BNE   = 4'd4,
    OP_BEQ   = 4'd5,
    OP_JMP   = 4'd6,
    OP_LSL   = 4'd7,
    OP_LSR   = 4'd8,
    OP_OUT   = 4'd9,
    OP_HALT  = 4'd15
  } op_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_RD_IR,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_EXEC,
    S_IO,
    S_HALT
  } seq_state_t;

  function automatic int wcnt_w(input int w);
    int r;
    r = $clog2(w + 1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_wait_timer.sv
// RAM wait-state counter: runs while a RAM state is active,
// flags the final cycle and clears itself when the access ends.
module ram_wait_timer
  import cpu_pkg::*;
#(
  parameter int RAM_WAIT = 0,
  parameter int CW       = 1
) (
  input  logic clock,
  input  logic n_reset,
  input  logic busy,
  output logic last
);

  logic [CW-1:0] wcnt_q;
  logic [CW-1:0] wcnt_d;

  assign last = (wcnt_q == CW'(RAM_WAIT));

  // Count inside a RAM state; zero on the last cycle and elsewhere
  always_comb begin
    wcnt_d = '0;
    if (busy && !last) begin
      wcnt_d = wcnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/sequencer_mc.sv
// Multi-cycle control sequencer for the accumulator CPU.
// Drives datapath strobes, RAM controls, io handshake and halt.
module sequencer_mc
  import cpu_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int OP_W     = 4,
  parameter int RAM_WAIT = 0
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            run,
  input  logic            io_ack,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            load_MAR,
  output logic            Addr_bus,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            ALU_lshift,
  output logic            ALU_rshift,
  output logic            RAM_NCE,
  output logic            RAM_NOE,
  output logic            RAM_NWE,
  output logic            io_req,
  output logic            halted
);

  localparam int CW = wcnt_w(RAM_WAIT);

  if (OP_W < 4 || WORD_W < 1) begin : g_param_check
    $error("sequencer_mc: OP_W must be >= 4 and WORD_W >= 1");
  end

  seq_state_t state_q;
  seq_state_t state_d;
  logic       ram_busy;
  logic       wlast;

  logic is_load, is_store, is_add, is_sub;
  logic is_bne, is_beq, is_jmp;
  logic is_lsl, is_lsr, is_out, is_halt;

  assign is_load  = (op == OP_W'(OP_LOAD));
  assign is_store = (op == OP_W'(OP_STORE));
  assign is_add   = (op == OP_W'(OP_ADD));
  assign is_sub   = (op == OP_W'(OP_SUB));
  assign is_bne   = (op == OP_W'(OP_BNE));
  assign is_beq   = (op == OP_W'(OP_BEQ));
  assign is_jmp   = (op == OP_W'(OP_JMP));
  assign is_lsl   = (op == OP_W'(OP_LSL));
  assign is_lsr   = (op == OP_W'(OP_LSR));
  assign is_out   = (op == OP_W'(OP_OUT));
  assign is_halt  = (op == OP_W'(OP_HALT));

  assign ram_busy = (state_q == S_RD_IR)
                 || (state_q == S_MEM_RD)
                 || (state_q == S_MEM_WR);

  ram_wait_timer #(
    .RAM_WAIT (RAM_WAIT),
    .CW       (CW)
  ) u_timer (
    .clock   (clock),
    .n_reset (n_reset),
    .busy    (ram_busy),
    .last    (wlast)
  );

  // State register
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; everything idles while reset is held
  always_comb begin
    state_d    = state_q;
    ACC_bus    = 1'b0;
    load_ACC   = 1'b0;
    PC_bus     = 1'b0;
    load_PC    = 1'b0;
    INC_PC     = 1'b0;
    load_IR    = 1'b0;
    load_MAR   = 1'b0;
    Addr_bus   = 1'b0;
    ALU_ACC    = 1'b0;
    ALU_add    = 1'b0;
    ALU_sub    = 1'b0;
    ALU_lshift = 1'b0;
    ALU_rshift = 1'b0;
    RAM_NCE    = 1'b1;
    RAM_NOE    = 1'b1;
    RAM_NWE    = 1'b1;
    io_req     = 1'b0;
    halted     = 1'b0;
    if (n_reset) begin
      unique case (state_q)
        S_FETCH: begin
          PC_bus   = 1'b1;
          load_MAR = 1'b1;
          INC_PC   = 1'b1;
          load_PC  = 1'b1;
          state_d  = S_RD_IR;
        end
        S_RD_IR: begin
          RAM_NCE = 1'b0;
          RAM_NOE = 1'b0;
          if (wlast) begin
            load_IR = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          Addr_bus = 1'b1;
          load_MAR = 1'b1;
          state_d  = S_FETCH;
          unique case (1'b1)
            is_load, is_add, is_sub: state_d = S_MEM_RD;
            is_store:                state_d = S_MEM_WR;
            is_lsl, is_lsr:          state_d = S_EXEC;
            is_out:                  state_d = S_IO;
            is_halt:                 state_d = S_HALT;
            is_jmp:                  load_PC = 1'b1;
            is_bne:                  load_PC = !z_flag;
            is_beq:                  load_PC = z_flag;
            default:                 state_d = S_FETCH;
          endcase
        end
        S_MEM_RD: begin
          RAM_NCE = 1'b0;
          RAM_NOE = 1'b0;
          if (wlast) begin
            load_ACC = 1'b1;
            ALU_ACC  = is_add || is_sub;
            ALU_add  = is_add;
            ALU_sub  = is_sub;
            state_d  = S_FETCH;
          end
        end
        S_MEM_WR: begin
          ACC_bus = 1'b1;
          RAM_NCE = 1'b0;
          RAM_NWE = 1'b0;
          if (wlast) begin
            state_d = S_FETCH;
          end
        end
        S_EXEC: begin
          load_ACC   = 1'b1;
          ALU_ACC    = 1'b1;
          ALU_lshift = is_lsl;
          ALU_rshift = is_lsr;
          state_d    = S_FETCH;
        end
        S_IO: begin
          io_req  = 1'b1;
          ACC_bus = 1'b1;
          if (io_ack) begin
            state_d = S_FETCH;
          end
        end
        S_HALT: begin
          halted = 1'b1;
          if (run) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sequencer_mc.sv
// Bench for sequencer_mc: per-cycle expected strobes are queued
// as each instruction is issued, then popped and compared.
module tb_sequencer_mc;
  import cpu_pkg::*;

  typedef struct packed {
    logic acc_bus;
    logic load_acc;
    logic pc_bus;
    logic load_pc;
    logic inc_pc;
    logic load_ir;
    logic load_mar;
    logic addr_bus;
    logic alu_acc;
    logic alu_add;
    logic alu_sub;
    logic alu_lsh;
    logic alu_rsh;
    logic nce;
    logic noe;
    logic nwe;
    logic io_req;
    logic halted;
  } out_t;

  typedef struct {
    out_t  exp;
    logic  ack;
    logic  rn;
    string name;
  } ent_t;

  logic       clock;
  logic [2:0] n_reset;
  logic [3:0] op [3];
  logic [2:0] z_flag;
  logic [2:0] run;
  logic [2:0] io_ack;
  logic [2:0] acc_bus, load_acc, pc_bus, load_pc, inc_pc, load_ir;
  logic [2:0] load_mar, addr_bus, alu_acc, alu_add, alu_sub;
  logic [2:0] alu_lsh, alu_rsh, nce, noe, nwe, io_req, halted;
  out_t       obs [3];

  ent_t sb[$];
  int   n_chk;
  int   n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sequencer_mc #(
      .WORD_W   (8),
      .OP_W     (4),
      .RAM_WAIT (g == 0 ? 0 : (g == 1 ? 2 : 3))
    ) u_dut (
      .clock      (clock),
      .n_reset    (n_reset[g]),
      .op         (op[g]),
      .z_flag     (z_flag[g]),
      .run        (run[g]),
      .io_ack     (io_ack[g]),
      .ACC_bus    (acc_bus[g]),
      .load_ACC   (load_acc[g]),
      .PC_bus     (pc_bus[g]),
      .load_PC    (load_pc[g]),
      .INC_PC     (inc_pc[g]),
      .load_IR    (load_ir[g]),
      .load_MAR   (load_mar[g]),
      .Addr_bus   (addr_bus[g]),
      .ALU_ACC    (alu_acc[g]),
      .ALU_add    (alu_add[g]),
      .ALU_sub    (alu_sub[g]),
      .ALU_lshift (alu_lsh[g]),
      .ALU_rshift (alu_rsh[g]),
      .RAM_NCE    (nce[g]),
      .RAM_NOE    (noe[g]),
      .RAM_NWE    (nwe[g]),
      .io_req     (io_req[g]),
      .halted     (halted[g])
    );
    assign obs[g] = {acc_bus[g], load_acc[g], pc_bus[g], load_pc[g],
                     inc_pc[g], load_ir[g], load_mar[g], addr_bus[g],
                     alu_acc[g], alu_add[g], alu_sub[g], alu_lsh[g],
                     alu_rsh[g], nce[g], noe[g], nwe[g], io_req[g],
                     halted[g]};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t o_idle();
    out_t o;
    o = '0;
    o.nce = 1'b1;
    o.noe = 1'b1;
    o.nwe = 1'b1;
    return o;
  endfunction

  task automatic push(input out_t o, input logic ack, input logic rn,
                      input string nm);
    ent_t e;
    e.exp  = o;
    e.ack  = ack;
    e.rn   = rn;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input string nm, input logic rn);
    out_t o;
    o = o_idle();
    o.pc_bus   = 1'b1;
    o.load_mar = 1'b1;
    o.inc_pc   = 1'b1;
    o.load_pc  = 1'b1;
    push(o, 1'b0, rn, {nm, "_fetch"});
  endtask

  // FETCH, RD_IR x (w+1), DECODE
  task automatic push_prologue(input int w, input logic ldpc,
                               input string nm, input logic rn);
    out_t o;
    push_fetch(nm, rn);
    for (int i = 0; i <= w; i++) begin
      o = o_idle();
      o.nce = 1'b0;
      o.noe = 1'b0;
      o.load_ir = (i == w);
      push(o, 1'b0, rn, $sformatf("%s_rdir%0d", nm, i));
    end
    o = o_idle();
    o.addr_bus = 1'b1;
    o.load_mar = 1'b1;
    o.load_pc  = ldpc;
    push(o, 1'b0, rn, {nm, "_decode"});
  endtask

  task automatic push_memrd(input int w, input logic add, input logic sub,
                            input string nm);
    out_t o;
    for (int i = 0; i <= w; i++) begin
      o = o_idle();
      o.nce = 1'b0;
      o.noe = 1'b0;
      if (i == w) begin
        o.load_acc = 1'b1;
        o.alu_acc  = add | sub;
        o.alu_add  = add;
        o.alu_sub  = sub;
      end
      push(o, 1'b0, 1'b0, $sformatf("%s_memrd%0d", nm, i));
    end
  endtask

  task automatic push_memwr(input int n, input string nm);
    out_t o;
    for (int i = 0; i < n; i++) begin
      o = o_idle();
      o.acc_bus = 1'b1;
      o.nce = 1'b0;
      o.nwe = 1'b0;
      push(o, 1'b0, 1'b0, $sformatf("%s_memwr%0d", nm, i));
    end
  endtask

  task automatic push_exec(input logic lsl, input string nm);
    out_t o;
    o = o_idle();
    o.load_acc = 1'b1;
    o.alu_acc  = 1'b1;
    o.alu_lsh  = lsl;
    o.alu_rsh  = !lsl;
    push(o, 1'b0, 1'b0, {nm, "_exec"});
  endtask

  task automatic push_io(input logic ack, input string nm);
    out_t o;
    o = o_idle();
    o.io_req  = 1'b1;
    o.acc_bus = 1'b1;
    push(o, ack, 1'b0, nm);
  endtask

  task automatic push_halt(input logic rn, input string nm);
    out_t o;
    o = o_idle();
    o.halted = 1'b1;
    push(o, 1'b0, rn, nm);
  endtask

  // Drain the scoreboard one cycle per entry against instance g
  task automatic run_sb(input int g);
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      io_ack[g] = e.ack;
      run[g]    = e.rn;
      @(negedge clock);
      n_chk++;
      if (obs[g] !== e.exp) begin
        $display("FAIL %s: got %h expected %h", e.name, obs[g], e.exp);
      end else begin
        n_pass++;
      end
      @(posedge clock);
      #1;
    end
    io_ack[g] = 1'b0;
    run[g]    = 1'b0;
  endtask

  task automatic set_op(input int g, input op_t o, input logic z);
    op[g]     = 4'(o);
    z_flag[g] = z;
  endtask

  task automatic release_rst(input int g);
    @(posedge clock);
    #1;
    n_reset[g] = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = '0;
    z_flag  = '0;
    run     = '0;
    io_ack  = '0;
    for (int g = 0; g < 3; g++) op[g] = 4'(OP_LOAD);
    #13;
    for (int g = 0; g < 3; g++) begin
      n_chk++;
      if (obs[g] !== o_idle()) begin
        $display("FAIL reset_idle%0d: got %h expected %h",
                 g, obs[g], o_idle());
      end else begin
        n_pass++;
      end
    end
    release_rst(0);
  endtask

  task automatic test_load_add();
    set_op(0, OP_LOAD, 1'b0);
    push_prologue(0, 1'b0, "load", 1'b0);
    push_memrd(0, 1'b0, 1'b0, "load");
    run_sb(0);
    set_op(0, OP_ADD, 1'b0);
    push_prologue(0, 1'b0, "add", 1'b0);
    push_memrd(0, 1'b1, 1'b0, "add");
    run_sb(0);
    set_op(0, OP_SUB, 1'b1);
    push_prologue(0, 1'b0, "sub", 1'b0);
    push_memrd(0, 1'b0, 1'b1, "sub");
    run_sb(0);
  endtask

  task automatic test_branch();
    set_op(0, OP_BEQ, 1'b1);
    push_prologue(0, 1'b1, "beq_z1", 1'b0);
    run_sb(0);
    set_op(0, OP_BNE, 1'b1);
    push_prologue(0, 1'b0, "bne_z1", 1'b0);
    run_sb(0);
    set_op(0, OP_BNE, 1'b0);
    push_prologue(0, 1'b1, "bne_z0", 1'b0);
    run_sb(0);
    set_op(0, OP_BEQ, 1'b0);
    push_prologue(0, 1'b0, "beq_z0", 1'b0);
    run_sb(0);
    set_op(0, OP_JMP, 1'b0);
    push_prologue(0, 1'b1, "jmp_run", 1'b1);
    run_sb(0);
    op[0] = 4'd12;
    push_prologue(0, 1'b0, "undef", 1'b0);
    run_sb(0);
  endtask

  task automatic test_shift();
    set_op(0, OP_LSL, 1'b0);
    push_prologue(0, 1'b0, "lsl", 1'b0);
    push_exec(1'b1, "lsl");
    run_sb(0);
    set_op(0, OP_LSR, 1'b0);
    push_prologue(0, 1'b0, "lsr", 1'b0);
    push_exec(1'b0, "lsr");
    run_sb(0);
  endtask

  task automatic test_out();
    set_op(0, OP_OUT, 1'b0);
    push_prologue(0, 1'b0, "out", 1'b0);
    for (int i = 0; i < 6; i++) begin
      push_io(i == 5, $sformatf("out_io%0d", i));
    end
    run_sb(0);
    push_prologue(0, 1'b0, "out_fast", 1'b0);
    push_io(1'b1, "out_fast_io");
    run_sb(0);
  endtask

  task automatic test_halt();
    set_op(0, OP_HALT, 1'b0);
    push_prologue(0, 1'b0, "halt", 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_halt(1'b0, $sformatf("halt_wait%0d", i));
    end
    push_halt(1'b1, "halt_run");
    run_sb(0);
    set_op(0, OP_LSL, 1'b0);
    push_prologue(0, 1'b0, "post_halt", 1'b0);
    push_exec(1'b1, "post_halt");
    run_sb(0);
  endtask

  task automatic test_back_to_back();
    release_rst(1);
    set_op(1, OP_STORE, 1'b0);
    push_prologue(2, 1'b0, "w2_store", 1'b0);
    push_memwr(3, "w2_store");
    run_sb(1);
    set_op(1, OP_ADD, 1'b0);
    push_prologue(2, 1'b0, "w2_add", 1'b0);
    push_memrd(2, 1'b1, 1'b0, "w2_add");
    run_sb(1);
    set_op(1, OP_JMP, 1'b0);
    push_prologue(2, 1'b1, "w2_jmp", 1'b0);
    push_fetch("w2_end", 1'b0);
    run_sb(1);
  endtask

  task automatic test_reset_mid();
    release_rst(2);
    set_op(2, OP_STORE, 1'b0);
    push_prologue(3, 1'b0, "w3_store", 1'b0);
    push_memwr(2, "w3_store");
    run_sb(2);
    #2;
    n_reset[2] = 1'b0;
    #1;
    n_chk++;
    if (obs[2] !== o_idle()) begin
      $display("FAIL rst_mid_wr: got %h expected %h", obs[2], o_idle());
    end else begin
      n_pass++;
    end
    release_rst(2);
    set_op(2, OP_LSR, 1'b0);
    push_prologue(3, 1'b0, "w3_lsr", 1'b0);
    push_exec(1'b0, "w3_lsr");
    push_fetch("w3_end", 1'b0);
    run_sb(2);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_load_add();
    test_branch();
    test_shift();
    test_out();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
